input_conditioner: RTL and testbench
====================================

# input_conditioner

Front-end conditioning stage that feeds the 8-bit add-shift multiplier's control unit and B/operand path. It converts the board's raw active-low push buttons (Execute, ClearA_LoadB) into synchronized, debounced, single-cycle active-high pulses and held levels. It synchronizes the 8 operand switches and latches an operand snapshot on every ClearA_LoadB pulse. It suppresses new commands while the multiplier reports Busy.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required after the first changed sample; ≥2; board build overrides to 500000.
- Clk  in  1  system clock; sole clock.
- Reset  in  1  synchronous, active-high reset.
- Execute  in  1  raw Run button, active-low, asynchronous.
- clearALoadB  in  1  raw ClearA_LoadB button, active-low, asynchronous.
- Switches  in  8  raw operand switches, asynchronous.
- Busy  in  1  multiplier control unit is mid-operation (synchronous to Clk).
- Run_pulse  out  1  one-cycle start command.
- Run_level  out  1  debounced Run button held.
- ClearA_LoadB_pulse  out  1  one-cycle clear-A / load-B command.
- ClearA_LoadB_level  out  1  debounced ClearA_LoadB held.
- Switches_S  out  8  two-flop-synchronized switches.
- Switches_L  out  8  operand snapshot taken at the ClearA_LoadB pulse.

## Operation
- Each button is inverted to active-high, then passes through a 2-flop synchronizer (s1, s2) and a per-button debounce FSM with a counter of width $clog2(DEBOUNCE_CYCLES).
- FSM states:
  - IDLE → PRESS_WAIT when s2=1 (cnt←0).
  - PRESS_WAIT, s2=1: if cnt==DEBOUNCE_CYCLES-1 → PRESSED, else cnt++. s2=0 → IDLE (cnt←0).
  - PRESSED → RELEASE_WAIT when s2=0 (cnt←0).
  - RELEASE_WAIT, s2=0: if cnt==DEBOUNCE_CYCLES-1 → IDLE, else cnt++. s2=1 → PRESSED with no new pulse.
- Pulse is a registered output, set only on the PRESS_WAIT→PRESSED edge, and only if Busy=0 at that same edge.
  - If Busy=1 there, the press is consumed: FSM still enters PRESSED, no pulse, no deferred firing.
  - A new pulse requires a full return to IDLE.
- Level = state ∈ {PRESSED, RELEASE_WAIT}.
- Switches_L loads Switches_S on the same edge that sets ClearA_LoadB_pulse. It is unchanged otherwise, including on suppressed presses.
- The two buttons are fully independent; simultaneous qualifying presses give pulses in the same cycle.
- Reset:
  - Sync flops ← 0 (released).
  - FSMs ← IDLE, counters ← 0.
  - All pulses and levels ← 0.
  - Switches_S and Switches_L ← 8'h00.
  - Reset during any state aborts with no pulse, regardless of input.

## Timing
- Let edge 0 be the first clock edge at which a raw button is sampled low, and the input stays low. The pulse register sets at edge 2+DEBOUNCE_CYCLES and is high for exactly the following cycle.
- Level rises at the same edge as the pulse.
- Level falls at edge 2+DEBOUNCE_CYCLES after the first edge sampling the button high, given the input stays high.
- Any bounce restarts the count. The latency is measured from the start of the final stable run.
- Switches → Switches_S latency: 2 edges.
- Pulse is never high for two consecutive cycles.
- Busy is sampled only at the qualifying edge.

## Structure
- Package input_conditioner_pkg holds:
  - typedef enum logic [1:0] debounce_state_t {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT};
  - localparam DEBOUNCE_SIM = 16;
  - localparam DEBOUNCE_BOARD = 500000.
- Sub-module button_debounce contains the synchronizer, FSM, counter, and the Busy-qualified pulse and level. It is instantiated twice.
- The top level holds the switch synchronizer and the Switches_L register.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
1. Clean press: Execute low from edge 0 for 20 cycles, Busy=0 → Run_pulse high only in the cycle after edge 6. Run_level high from edge 6. After release at edge 20, Run_level low from edge 26.
2. Bounce: Execute low at edges 0–2, high at 3, low from 4 onward → single Run_pulse, set at edge 10. After release, a bounce in RELEASE_WAIT produces no second pulse.
3. Busy suppression: Busy=1 during a press → no Run_pulse, Run_level still rises. Release, then re-press with Busy=0 → exactly one pulse.
4. Glitch and reset: Execute low for 3 cycles → no pulse, level stays 0. Reset asserted during PRESS_WAIT → no pulse, FSM in IDLE, all outputs 0.
5. Operand capture: Switches=8'hA5 → Switches_S=8'hA5 after 2 edges. ClearA_LoadB press → Switches_L=8'hA5 in the same cycle as the pulse. Switches then changed to 8'h3C with no press → Switches_L holds 8'hA5.
6. Simultaneous: both buttons low from edge 0, Busy=0 → Run_pulse and ClearA_LoadB_pulse both high in the cycle after edge 6.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared types and constants for the multiplier front-end input conditioner.
//   debounce_state_t : per-button debounce FSM state encoding
//   DEBOUNCE_SIM     : short debounce window for simulation builds
//   DEBOUNCE_BOARD   : debounce window for the board build
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } debounce_state_t;

    localparam int DEBOUNCE_SIM   = 16;
    localparam int DEBOUNCE_BOARD = 500000;

endpackage

// File: rtl/input_conditioner_if.sv
// Board-side bundle of the input conditioner.
//   master : drives raw buttons (active-low), raw switches and Busy;
//            observes conditioned pulses/levels, switch values and FSM states
//   slave  : the conditioner itself
// Handshake: there is no valid/ready pair. A command is a single-cycle,
// active-high pulse that is valid in the cycle it is high; the consumer
// must act on it in that cycle. Busy only gates whether a new pulse fires.
interface input_conditioner_if;
    import input_conditioner_pkg::*;

    logic            Execute;
    logic            clearALoadB;
    logic [7:0]      Switches;
    logic            Busy;
    logic            Run_pulse;
    logic            Run_level;
    logic            ClearA_LoadB_pulse;
    logic            ClearA_LoadB_level;
    logic [7:0]      Switches_S;
    logic [7:0]      Switches_L;
    debounce_state_t run_state;
    debounce_state_t clr_state;

    modport master (
        output Execute, clearALoadB, Switches, Busy,
        input  Run_pulse, Run_level, ClearA_LoadB_pulse, ClearA_LoadB_level,
        input  Switches_S, Switches_L, run_state, clr_state
    );

    modport slave (
        input  Execute, clearALoadB, Switches, Busy,
        output Run_pulse, Run_level, ClearA_LoadB_pulse, ClearA_LoadB_level,
        output Switches_S, Switches_L, run_state, clr_state
    );

endinterface

// File: rtl/input_conditioner_button_debounce.sv
// One push button: 2-flop synchronizer, debounce FSM and Busy-qualified pulse.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_btn_n      : raw active-low button (asynchronous)
//   i_busy       : suppresses the pulse at the qualifying edge
//   o_pulse      : registered one-cycle command pulse
//   o_level      : debounced held level
//   o_fire       : combinational "pulse sets at this edge" (for capture logic)
//   o_state      : current FSM state (debug)
module button_debounce
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_btn_n,
    input  logic            i_busy,
    output logic            o_pulse,
    output logic            o_level,
    output logic            o_fire,
    output debounce_state_t o_state
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            r_s1;
    logic            r_s2;
    debounce_state_t r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_pulse;

    debounce_state_t w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic            w_fire;

    // A press is consumed even when Busy suppresses the pulse: the FSM still
    // moves to PRESSED, so nothing fires later without a full release.
    assign w_fire = (r_state == PRESS_WAIT) && r_s2 && (r_cnt == CNT_LAST) && !i_busy;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (r_s2) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!r_s2) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = PRESSED;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!r_s2) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                // Bounce while releasing returns to PRESSED without a pulse.
                if (r_s2) begin
                    w_state_nxt = PRESSED;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_s1    <= ~i_btn_n;
            r_s2    <= r_s1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_fire;
        end
    end

    assign o_pulse = r_pulse;
    assign o_level = (r_state == PRESSED) || (r_state == RELEASE_WAIT);
    assign o_fire  = w_fire;
    assign o_state = r_state;

endmodule

// File: rtl/input_conditioner.sv
// Front-end conditioner for the add-shift multiplier: debounced Run and
// ClearA_LoadB commands, synchronized switches and an operand snapshot
// captured on each ClearA_LoadB pulse.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : input_conditioner_if slave modport (buttons, switches,
//                Busy in; pulses, levels, Switches_S/L, FSM states out)
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input_conditioner_if.slave    bus
);

    logic [7:0] r_sw_s1;
    logic [7:0] r_sw_s2;
    logic [7:0] r_sw_l;
    logic       w_run_fire;
    logic       w_clr_fire;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_btn_n (bus.Execute),
        .i_busy  (bus.Busy),
        .o_pulse (bus.Run_pulse),
        .o_level (bus.Run_level),
        .o_fire  (w_run_fire),
        .o_state (bus.run_state)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_btn_n (bus.clearALoadB),
        .i_busy  (bus.Busy),
        .o_pulse (bus.ClearA_LoadB_pulse),
        .o_level (bus.ClearA_LoadB_level),
        .o_fire  (w_clr_fire),
        .o_state (bus.clr_state)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sw_s1 <= 8'h00;
            r_sw_s2 <= 8'h00;
            r_sw_l  <= 8'h00;
        end else begin
            r_sw_s1 <= bus.Switches;
            r_sw_s2 <= r_sw_s1;
            // Snapshot lands on the same edge the ClearA_LoadB pulse sets.
            if (w_clr_fire) begin
                r_sw_l <= r_sw_s2;
            end
        end
    end

    assign bus.Switches_S = r_sw_s2;
    assign bus.Switches_L = r_sw_l;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;
  import input_conditioner_pkg::*;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;
  int   run_cnt;
  int   clr_cnt;
  logic prev_run;
  logic prev_clr;
  int   base_r;
  int   base_c;

  input_conditioner_if bus ();

  input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  // clock / reset block
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance n active edges, land 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // pulse scoreboard: counts pulses and flags back-to-back highs
  initial begin
    run_cnt  = 0;
    clr_cnt  = 0;
    prev_run = 1'b0;
    prev_clr = 1'b0;
  end

  always @(negedge Clk) begin
    if (bus.Run_pulse === 1'b1) begin
      run_cnt++;
      chk("run_pulse_single_cycle", {31'b0, prev_run}, 32'd0);
    end
    if (bus.ClearA_LoadB_pulse === 1'b1) begin
      clr_cnt++;
      chk("clr_pulse_single_cycle", {31'b0, prev_clr}, 32'd0);
    end
    prev_run = bus.Run_pulse;
    prev_clr = bus.ClearA_LoadB_pulse;
  end

  initial begin
    checks          = 0;
    errors          = 0;
    Reset           = 1'b1;
    bus.Execute     = 1'b1;
    bus.clearALoadB = 1'b1;
    bus.Switches    = 8'h00;
    bus.Busy        = 1'b0;

    // reset state
    step(3);
    chk("rst_run_pulse", {31'b0, bus.Run_pulse}, 32'd0);
    chk("rst_run_level", {31'b0, bus.Run_level}, 32'd0);
    chk("rst_clr_pulse", {31'b0, bus.ClearA_LoadB_pulse}, 32'd0);
    chk("rst_clr_level", {31'b0, bus.ClearA_LoadB_level}, 32'd0);
    chk("rst_sw_s", {24'b0, bus.Switches_S}, 32'h00);
    chk("rst_sw_l", {24'b0, bus.Switches_L}, 32'h00);
    chk("rst_run_state", {30'b0, bus.run_state}, {30'b0, IDLE});
    chk("rst_clr_state", {30'b0, bus.clr_state}, {30'b0, IDLE});
    Reset = 1'b0;
    step(4);

    // 1: clean press, pulse sets at edge 6, level falls 6 edges after release
    base_r = run_cnt;
    bus.Execute = 1'b0;
    step(6);
    chk("t1_pulse_e5", {31'b0, bus.Run_pulse}, 32'd0);
    chk("t1_level_e5", {31'b0, bus.Run_level}, 32'd0);
    step(1);
    chk("t1_pulse_e6", {31'b0, bus.Run_pulse}, 32'd1);
    chk("t1_level_e6", {31'b0, bus.Run_level}, 32'd1);
    step(1);
    chk("t1_pulse_e7", {31'b0, bus.Run_pulse}, 32'd0);
    chk("t1_level_e7", {31'b0, bus.Run_level}, 32'd1);
    chk("t1_count", run_cnt, base_r + 1);
    step(12);
    bus.Execute = 1'b1;
    step(6);
    chk("t1_level_rel_e25", {31'b0, bus.Run_level}, 32'd1);
    step(1);
    chk("t1_level_rel_e26", {31'b0, bus.Run_level}, 32'd0);
    chk("t1_state_idle", {30'b0, bus.run_state}, {30'b0, IDLE});

    // 2: bounce during press restarts the count; bounce during release gives no pulse
    base_r = run_cnt;
    bus.Execute = 1'b0;
    step(3);
    bus.Execute = 1'b1;
    step(1);
    bus.Execute = 1'b0;
    step(6);
    chk("t2_pulse_e9", {31'b0, bus.Run_pulse}, 32'd0);
    step(1);
    chk("t2_pulse_e10", {31'b0, bus.Run_pulse}, 32'd1);
    step(1);
    chk("t2_count", run_cnt, base_r + 1);
    bus.Execute = 1'b1;
    step(3);
    bus.Execute = 1'b0;
    step(1);
    bus.Execute = 1'b1;
    step(2);
    chk("t2_bounce_state", {30'b0, bus.run_state}, {30'b0, PRESSED});
    chk("t2_bounce_level", {31'b0, bus.Run_level}, 32'd1);
    step(10);
    chk("t2_rel_level", {31'b0, bus.Run_level}, 32'd0);
    chk("t2_count_after_bounce", run_cnt, base_r + 1);

    // 3: Busy suppresses the pulse; re-press when idle fires once
    base_r = run_cnt;
    bus.Busy = 1'b1;
    bus.Execute = 1'b0;
    step(7);
    chk("t3_busy_level", {31'b0, bus.Run_level}, 32'd1);
    chk("t3_busy_pulse", {31'b0, bus.Run_pulse}, 32'd0);
    step(2);
    bus.Busy = 1'b0;
    step(2);
    chk("t3_no_deferred", run_cnt, base_r);
    bus.Execute = 1'b1;
    step(8);
    chk("t3_rel_level", {31'b0, bus.Run_level}, 32'd0);
    bus.Execute = 1'b0;
    step(7);
    chk("t3_repress_pulse", {31'b0, bus.Run_pulse}, 32'd1);
    step(1);
    chk("t3_count", run_cnt, base_r + 1);
    bus.Execute = 1'b1;
    step(8);

    // 4: short glitch, then reset while in PRESS_WAIT
    base_r = run_cnt;
    bus.Switches = 8'h5A;
    bus.Execute = 1'b0;
    step(3);
    bus.Execute = 1'b1;
    step(8);
    chk("t4_glitch_count", run_cnt, base_r);
    chk("t4_glitch_level", {31'b0, bus.Run_level}, 32'd0);
    chk("t4_sw_s_pre", {24'b0, bus.Switches_S}, 32'h5A);
    bus.Execute = 1'b0;
    step(4);
    chk("t4_state_pw", {30'b0, bus.run_state}, {30'b0, PRESS_WAIT});
    Reset = 1'b1;
    step(1);
    chk("t4_rst_state", {30'b0, bus.run_state}, {30'b0, IDLE});
    chk("t4_rst_pulse", {31'b0, bus.Run_pulse}, 32'd0);
    chk("t4_rst_level", {31'b0, bus.Run_level}, 32'd0);
    chk("t4_rst_sw_s", {24'b0, bus.Switches_S}, 32'h00);
    step(2);
    chk("t4_rst_hold_state", {30'b0, bus.run_state}, {30'b0, IDLE});
    bus.Execute = 1'b1;
    Reset = 1'b0;
    step(8);
    chk("t4_after_count", run_cnt, base_r);
    chk("t4_after_state", {30'b0, bus.run_state}, {30'b0, IDLE});

    // 5: operand capture on ClearA_LoadB
    base_c = clr_cnt;
    chk("t5_sw_s_old", {24'b0, bus.Switches_S}, 32'h5A);
    bus.Switches = 8'hA5;
    step(1);
    chk("t5_sw_s_e0", {24'b0, bus.Switches_S}, 32'h5A);
    step(1);
    chk("t5_sw_s_e1", {24'b0, bus.Switches_S}, 32'hA5);
    bus.clearALoadB = 1'b0;
    step(6);
    chk("t5_sw_l_before", {24'b0, bus.Switches_L}, 32'h00);
    chk("t5_clr_pulse_e5", {31'b0, bus.ClearA_LoadB_pulse}, 32'd0);
    step(1);
    chk("t5_clr_pulse_e6", {31'b0, bus.ClearA_LoadB_pulse}, 32'd1);
    chk("t5_sw_l_e6", {24'b0, bus.Switches_L}, 32'hA5);
    chk("t5_clr_level", {31'b0, bus.ClearA_LoadB_level}, 32'd1);
    bus.Switches = 8'h3C;
    step(3);
    chk("t5_sw_s_new", {24'b0, bus.Switches_S}, 32'h3C);
    chk("t5_sw_l_hold", {24'b0, bus.Switches_L}, 32'hA5);
    bus.clearALoadB = 1'b1;
    step(10);
    chk("t5_sw_l_hold2", {24'b0, bus.Switches_L}, 32'hA5);
    chk("t5_clr_level_rel", {31'b0, bus.ClearA_LoadB_level}, 32'd0);
    chk("t5_clr_count", clr_cnt, base_c + 1);

    // 6: simultaneous presses pulse together
    base_r = run_cnt;
    base_c = clr_cnt;
    bus.Execute = 1'b0;
    bus.clearALoadB = 1'b0;
    step(6);
    chk("t6_run_e5", {31'b0, bus.Run_pulse}, 32'd0);
    chk("t6_clr_e5", {31'b0, bus.ClearA_LoadB_pulse}, 32'd0);
    step(1);
    chk("t6_run_e6", {31'b0, bus.Run_pulse}, 32'd1);
    chk("t6_clr_e6", {31'b0, bus.ClearA_LoadB_pulse}, 32'd1);
    step(1);
    chk("t6_run_count", run_cnt, base_r + 1);
    chk("t6_clr_count", clr_cnt, base_c + 1);
    chk("t6_sw_l_recapture", {24'b0, bus.Switches_L}, 32'h3C);
    bus.Execute = 1'b1;
    bus.clearALoadB = 1'b1;
    step(8);
    chk("t6_run_level_rel", {31'b0, bus.Run_level}, 32'd0);
    chk("t6_clr_level_rel", {31'b0, bus.ClearA_LoadB_level}, 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
